// File: rtl/instr_sequencer.sv
// Instruction fetch/decode/issue sequencer driving op/op1/op2 into the ALU datapath.
// Optional build macro SEQ_STEP_EN adds a step input for single-instruction execution.
module instr_sequencer #(
    parameter int unsigned     PC_W     = 10,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [3:0]      NOP_OP   = 4'b1110
) (
    input  logic            clk,
    input  logic            init,
    input  logic            run,
`ifdef SEQ_STEP_EN
    input  logic            step,
`endif
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_rdata,
    output logic [3:0]      op,
    output logic [2:0]      op1,
    output logic [2:0]      op2,
    input  logic [15:0]     alu_y,
    input  logic            alu_c,
    input  logic            alu_v,
    input  logic            alu_z,
    output logic [15:0]     result,
    output logic [2:0]      flags,
    output logic [PC_W-1:0] pc,
    output logic            retire,
    output logic            halted
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMemwait,
        StRetire,
        StHalt
    } state_e;

    state_e          state_q;
    logic [15:0]     ir_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] npc_q;
    logic [PC_W-1:0] imem_addr_q;
    logic            imem_req_q;
    logic [3:0]      op_q;
    logic [2:0]      op1_q;
    logic [2:0]      op2_q;
    logic [15:0]     result_q;
    logic [2:0]      flags_q;
    logic            retire_q;
    logic            halted_q;

    logic            start_fetch;
    logic            resume_fetch;
    logic [PC_W-1:0] pc_inc;

`ifdef SEQ_STEP_EN
    // Stepping: every instruction returns to IDLE and waits for the next step pulse.
    assign start_fetch  = run & step;
    assign resume_fetch = 1'b0;
`else
    assign start_fetch  = run;
    assign resume_fetch = run;
`endif

    assign pc_inc = pc_q + PC_W'(1);

    always_ff @(posedge clk or negedge init) begin
        if (!init) begin
            state_q     <= StIdle;
            ir_q        <= '0;
            pc_q        <= RESET_PC;
            npc_q       <= RESET_PC;
            imem_addr_q <= '0;
            imem_req_q  <= 1'b0;
            op_q        <= NOP_OP;
            op1_q       <= '0;
            op2_q       <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            retire_q    <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            retire_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_fetch) begin
                        state_q     <= StFetch;
                        imem_req_q  <= 1'b1;
                        imem_addr_q <= pc_q;
                    end
                end
                StFetch: begin
                    // Request stays up until acked, regardless of run.
                    if (imem_ack) begin
                        ir_q       <= imem_rdata;
                        imem_req_q <= 1'b0;
                        state_q    <= StDecode;
                    end
                end
                StDecode: begin
                    op_q    <= ir_q[15:12];
                    op1_q   <= ir_q[11:9];
                    op2_q   <= ir_q[8:6];
                    state_q <= StExec;
                end
                StExec: begin
                    npc_q <= pc_inc;
                    case (ir_q[15:12])
                        4'b0101, 4'b0110: begin
                            state_q <= StMemwait;
                        end
                        4'b1100: begin
                            if (flags_q[0]) npc_q <= ir_q[PC_W-1:0];
                            state_q  <= StRetire;
                            retire_q <= 1'b1;
                        end
                        4'b1101: begin
                            state_q  <= StHalt;
                            halted_q <= 1'b1;
                        end
                        4'b1110, 4'b1111: begin
                            state_q  <= StRetire;
                            retire_q <= 1'b1;
                        end
                        default: begin
                            result_q <= alu_y;
                            flags_q  <= {alu_c, alu_v, alu_z};
                            state_q  <= StRetire;
                            retire_q <= 1'b1;
                        end
                    endcase
                    if (ir_q[15:12] != 4'b0101 && ir_q[15:12] != 4'b0110) begin
                        op_q  <= NOP_OP;
                        op1_q <= '0;
                        op2_q <= '0;
                    end
                end
                StMemwait: begin
                    op_q     <= NOP_OP;
                    op1_q    <= '0;
                    op2_q    <= '0;
                    state_q  <= StRetire;
                    retire_q <= 1'b1;
                end
                StRetire: begin
                    pc_q <= npc_q;
                    if (resume_fetch) begin
                        state_q     <= StFetch;
                        imem_req_q  <= 1'b1;
                        imem_addr_q <= npc_q;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StHalt: begin
                    state_q <= StHalt;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;
    assign op        = op_q;
    assign op1       = op1_q;
    assign op2       = op2_q;
    assign result    = result_q;
    assign flags     = flags_q;
    assign pc        = pc_q;
    assign retire    = retire_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized self-checking bench for instr_sequencer against a per-instruction reference model.
module tb_instr_sequencer;

    localparam int unsigned PC_W = 10;
    localparam logic [3:0]  NOP  = 4'b1110;

    logic            clk        = 1'b0;
    logic            init       = 1'b1;
    logic            run        = 1'b0;
    logic            imem_ack   = 1'b0;
    logic [15:0]     imem_rdata = '0;
    logic [15:0]     alu_y      = '0;
    logic            alu_c      = 1'b0;
    logic            alu_v      = 1'b0;
    logic            alu_z      = 1'b0;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic [3:0]      op;
    logic [2:0]      op1;
    logic [2:0]      op2;
    logic [15:0]     result;
    logic [2:0]      flags;
    logic [PC_W-1:0] pc;
    logic            retire;
    logic            halted;

    int checks   = 0;
    int failures = 0;

    // Architectural model state
    logic [PC_W-1:0] m_pc;
    logic [15:0]     m_result;
    logic [2:0]      m_flags;

    instr_sequencer #(
        .PC_W    (PC_W),
        .RESET_PC('0),
        .NOP_OP  (NOP)
    ) dut (
        .clk       (clk),
        .init      (init),
        .run       (run),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .op        (op),
        .op1       (op1),
        .op2       (op2),
        .alu_y     (alu_y),
        .alu_c     (alu_c),
        .alu_v     (alu_v),
        .alu_z     (alu_z),
        .result    (result),
        .flags     (flags),
        .pc        (pc),
        .retire    (retire),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_vals(input string tag);
        check({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        check({tag, "_addr"}, 32'(imem_addr), 32'd0);
        check({tag, "_op"}, 32'(op), 32'(NOP));
        check({tag, "_op1"}, 32'(op1), 32'd0);
        check({tag, "_op2"}, 32'(op2), 32'd0);
        check({tag, "_result"}, 32'(result), 32'd0);
        check({tag, "_flags"}, 32'(flags), 32'd0);
        check({tag, "_pc"}, 32'(pc), 32'd0);
        check({tag, "_retire"}, {31'd0, retire}, 32'd0);
        check({tag, "_halted"}, {31'd0, halted}, 32'd0);
    endtask

    // Fetch and run one instruction, comparing timing and architectural effects with the model.
    task automatic do_instr(input logic [15:0] w, input int dly, input logic drop,
                            input logic [15:0] y, input logic [2:0] cvz);
        int              cyc;
        int              n_op;
        int              exp_lat;
        int              exp_nop;
        logic [3:0]      opc;
        logic [3:0]      s_op;
        logic [2:0]      s_op1;
        logic [2:0]      s_op2;
        logic [PC_W-1:0] nxt;
        alu_y = y;
        {alu_c, alu_v, alu_z} = cvz;
        opc = w[15:12];
        cyc = 0;
        while (!imem_req && cyc < 50) begin
            tick();
            cyc++;
        end
        check("req_rise", {31'd0, imem_req}, 32'd1);
        check("fetch_addr", 32'(imem_addr), 32'(m_pc));
        check("fetch_pc", 32'(pc), 32'(m_pc));
        if (drop) run = 1'b0;
        cyc = 1;
        for (int i = 0; i < dly; i++) begin
            tick();
            cyc++;
            check("req_hold", {31'd0, imem_req}, 32'd1);
        end
        imem_ack   = 1'b1;
        imem_rdata = w;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 16'($urandom);
        cyc++;
        check("req_drop", {31'd0, imem_req}, 32'd0);
        n_op  = 0;
        s_op  = NOP;
        s_op1 = '0;
        s_op2 = '0;
        while (!retire && !halted && cyc < 30) begin
            if (op != NOP) begin
                n_op++;
                s_op  = op;
                s_op1 = op1;
                s_op2 = op2;
            end
            tick();
            cyc++;
        end
        exp_lat = ((opc == 4'd5 || opc == 4'd6) ? 5 : 4) + dly;
        exp_nop = (opc == 4'd14) ? 0 : ((opc == 4'd5 || opc == 4'd6) ? 2 : 1);
        check("latency", 32'(cyc), 32'(exp_lat));
        check("op_cycles", 32'(n_op), 32'(exp_nop));
        if (exp_nop > 0) begin
            check("op", 32'(s_op), 32'(opc));
            check("op1", 32'(s_op1), 32'(w[11:9]));
            check("op2", 32'(s_op2), 32'(w[8:6]));
        end
        if (opc == 4'd13) begin
            check("halted", {31'd0, halted}, 32'd1);
            check("halt_pc", 32'(pc), 32'(m_pc));
            return;
        end
        nxt = m_pc + 1'b1;
        case (opc)
            4'd5, 4'd6, 4'd14, 4'd15: ;
            4'd12: if (m_flags[0]) nxt = w[PC_W-1:0];
            default: begin
                m_result = y;
                m_flags  = cvz;
            end
        endcase
        check("retire", {31'd0, retire}, 32'd1);
        check("halted_low", {31'd0, halted}, 32'd0);
        check("result", 32'(result), 32'(m_result));
        check("flags", 32'(flags), 32'(m_flags));
        check("retire_pc", 32'(pc), 32'(m_pc));
        m_pc = nxt;
        if (drop) begin
            for (int i = 0; i < 3; i++) begin
                tick();
                check("idle_no_req", {31'd0, imem_req}, 32'd0);
                check("idle_no_retire", {31'd0, retire}, 32'd0);
            end
            check("idle_pc", 32'(pc), 32'(m_pc));
            run = 1'b1;
        end
    endtask

    initial begin
        logic [15:0] w;
        int          n;
        #2 init = 1'b0;
        #1;
        reset_vals("reset");
        m_pc     = '0;
        m_result = '0;
        m_flags  = '0;
        repeat (2) @(posedge clk);
        #1;
        init = 1'b1;
        run  = 1'b1;

        do_instr(16'h3280, 0, 1'b0, 16'h0005, 3'b000);
        do_instr(16'h5200, 0, 1'b0, 16'hBEEF, 3'b111);
        do_instr(16'h1000, 0, 1'b0, 16'h0000, 3'b001);
        do_instr(16'hC07B, 0, 1'b0, 16'h1234, 3'b000);
        do_instr(16'h2040, 1, 1'b0, 16'h0042, 3'b000);
        do_instr(16'hC07B, 0, 1'b0, 16'h4321, 3'b001);
        do_instr(16'h1000, 0, 1'b0, 16'h0000, 3'b101);
        do_instr(16'hC3FF, 2, 1'b0, 16'h0000, 3'b000);
        do_instr(16'hE000, 0, 1'b0, 16'h7777, 3'b111);
        do_instr(16'h6440, 1, 1'b0, 16'h5555, 3'b010);
        do_instr(16'h4440, 3, 1'b1, 16'h00AA, 3'b100);

        for (int k = 0; k < 40; k++) begin
            w = 16'($urandom);
            while (w[15:12] == 4'd13) w = 16'($urandom);
            do_instr(w, int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                     16'($urandom), 3'($urandom));
        end

        n = 0;
        while (!imem_req && n < 50) begin
            tick();
            n++;
        end
        check("rst_pre_req", {31'd0, imem_req}, 32'd1);
        #3 init = 1'b0;
        #1;
        reset_vals("midfetch");
        m_pc     = '0;
        m_result = '0;
        m_flags  = '0;
        @(posedge clk);
        #1;
        init = 1'b1;

        do_instr(16'h7100, 0, 1'b0, 16'h0F0F, 3'b010);
        do_instr(16'hF000, 1, 1'b0, 16'h1111, 3'b000);
        do_instr(16'hD000, 0, 1'b0, 16'h2222, 3'b111);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("halt_no_req", {31'd0, imem_req}, 32'd0);
            check("halt_no_retire", {31'd0, retire}, 32'd0);
            check("halt_sticky", {31'd0, halted}, 32'd1);
        end
        check("halt_pc_frozen", 32'(pc), 32'(m_pc));
        check("halt_result", 32'(result), 32'(m_result));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Instruction fetch/decode/issue controller: the initiator that drives the opcode and operand addresses (op, op1, op2) into the ALU/register-file/RAM datapath.
- Fetches 16-bit instruction words over a req/ack port, decodes them and holds the controls stable for the required cycles.
- Captures the ALU result and flags, then advances the PC, taking a jump when the instruction calls for one.

Parameters:
PC_W, 10, program counter and instruction address width
RESET_PC, 0, PC value loaded on reset
NOP_OP, 4'b1110, opcode driven whenever no instruction is being issued

Ports:
clk  in  1  clock, rising-edge; datapath memories write on falling edge
init  in  1  asynchronous active-low reset (init=0 resets)
run  in  1  1 = fetch and execute; 0 = stop at next instruction boundary
imem_req  out  1  fetch request
imem_addr  out  PC_W  fetch address (= pc while imem_req=1)
imem_ack  in  1  fetch acknowledge, imem_rdata valid in same cycle
imem_rdata  in  16  instruction word
op  out  4  ALU opcode
op1  out  3  operand-1 register address
op2  out  3  operand-2 register address
alu_y  in  16  ALU result
alu_c, alu_v, alu_z  in  1 each  ALU carry/overflow/zero
result  out  16  last captured ALU result
flags  out  3  {C,V,Z} last captured
pc  out  PC_W  current program counter
retire  out  1  one-cycle pulse per completed instruction
halted  out  1  sticky halt indication

Behaviour:
- Instruction format: [15:12]=op, [11:9]=op1, [8:6]=op2, [PC_W-1:0]=jump target (JZ only).
- Reset (init=0, async): state=IDLE, pc=RESET_PC, op=NOP_OP, op1=op2=0, imem_req=0, imem_addr=0, result=0, flags=0, retire=0, halted=0, IR=0.
- States: IDLE, FETCH, DECODE, EXEC, MEMWAIT, RETIRE, HALT.
- IDLE: if run=1, go to FETCH next cycle.
- FETCH: imem_req=1, imem_addr=pc. Hold until imem_ack=1 at a rising edge; capture imem_rdata into IR; go to DECODE. imem_req drops the cycle after the ack. Requests are never withdrawn before the ack, even if run falls.
- DECODE (1 cycle): register op/op1/op2 from IR. These stay stable through EXEC/MEMWAIT.
- Outside DECODE..MEMWAIT, op=NOP_OP. This keeps the combinational store/load decodes from firing spuriously.
- EXEC:
  - op 0000-0100, 0111-1011: capture alu_y into result and {alu_c,alu_v,alu_z} into flags at the end of EXEC; go to RETIRE.
  - 0101 (store), 0110 (load): go to MEMWAIT, so the controls span a full falling edge. result and flags are unchanged.
  - 1100 (JZ): if flags[0]=1, next pc = IR[PC_W-1:0], else pc+1. No capture.
  - 1101 (HALT): go to HALT.
  - 1110, 1111 (NOP): no capture.
- MEMWAIT (1 cycle): go to RETIRE.
- RETIRE: retire=1 for one cycle; pc updates (pc+1 wraps 2^PC_W-1 -> 0, or the jump target). Go to FETCH if run=1, else IDLE.
- HALT: halted=1 and sticky; pc frozen at the HALT address; no retire pulse; only reset exits.
- Latency with same-cycle ack: ALU/JZ/NOP take 4 cycles fetch-to-retire; load/store take 5. Each cycle of ack delay adds one.
- run=0 mid-instruction: the current instruction completes and retires, then IDLE.
- Reset mid-fetch or mid-memory-op: immediate return to reset values; the in-flight instruction is abandoned.

Optional Feature:
- SEQ_STEP_EN defined: adds input step (1 bit). In RETIRE the next state is always IDLE. IDLE goes to FETCH only when run=1 and step=1 at the same edge, so each step pulse executes exactly one instruction.
- Undefined: no step port; behaviour as above.

Test Plan:
- Reset with init=0 mid-FETCH (imem_req=1) -> all outputs at reset values asynchronously, op=4'b1110, pc=0.
- run=1, ack same cycle, word 16'h3280 (ADD r1,r2), alu_y=16'h0005, alu_z=0 -> op=4'b0011, op1=1, op2=2 from DECODE through EXEC; result=5, flags=3'b000; retire pulses 4 cycles after imem_req rises; pc=1.
- Word 16'h5200 (store r1,[r0]) -> op=4'b0101 held for 2 cycles with a falling edge inside; result unchanged; retire on cycle 5.
- flags Z=1, then 16'hC07B (JZ 0x07B) -> next imem_addr=0x07B. With Z=0 -> pc+1. pc=1023 with NOP -> pc wraps to 0.
- 16'hD000 (HALT) -> halted=1, no retire, imem_req stays 0 for 20 cycles with run=1.
- imem_ack delayed 3 cycles, run dropped during FETCH -> instruction still completes and retires; then IDLE with imem_req=0.
